msg_frame_ctrl: RTL and testbench

MSG_FRAME_CTRL -- requirements
Module: msg_frame_ctrl

---
 rtl/msg_frame_pkg.sv | 23 ++
 rtl/msg_frame_timer.sv | 30 +++
 rtl/msg_frame_ctrl.sv | 164 ++++++++++++++++
 tb/tb_msg_frame_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_frame_pkg.sv
// Shared types and constants for the message framing controller.
package msg_frame_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    HOLD = 3'd4
  } frameState_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BADLEN  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CSUM    = 2'd3;

  localparam logic [7:0] SYNC_DEFAULT = 8'h7E;

  function automatic logic [7:0] satInc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/msg_frame_timer.sv
// Inter-byte timeout counter: cleared by any received byte, runs only while enabled,
// and emits a single-cycle expiry on the TIMEOUT_CYC-th idle clock.
module msg_frame_timer #(
  parameter int TIMEOUT_CYC = 69440
) (
  input  logic clk,
  input  logic rstN,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  assign expired = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt <= '0;
    end else if (clr || !en || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/msg_frame_ctrl.sv
// Sync/length/payload[/checksum] frame receiver writing payload into a message buffer.
// Optional checksum byte enabled by defining MSG_FRAME_CSUM_EN.
module msg_frame_ctrl
  import msg_frame_pkg::*;
#(
  parameter int         MAX_LEN     = 10,
  parameter int         TIMEOUT_CYC = 69440,
  parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       buf_we,
  output logic [3:0] buf_addr,
  output logic [7:0] buf_wdata,
  output logic       done_valid,
  input  logic       done_ack,
  output logic [3:0] frame_len,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  frameState_t state, stateNext;
  logic [3:0]  lenQ, lenNext, idxQ, idxNext;
  logic        weNext, doneNext, errNext;
  logic [3:0]  addrNext, flenNext;
  logic [7:0]  wdataNext, dropNext;
  logic [1:0]  codeNext;
  logic        timerEn, timeout;
`ifdef MSG_FRAME_CSUM_EN
  logic [7:0]  csumQ, csumNext;
`endif

  assign timerEn = (state == LEN) || (state == DATA) || (state == CSUM);
  assign busy    = (state != IDLE);

  msg_frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) uTimer (
    .clk    (CLK),
    .rstN   (reset),
    .clr    (rx_valid),
    .en     (timerEn),
    .expired(timeout)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lenQ       <= '0;
      idxQ       <= '0;
      buf_we     <= 1'b0;
      buf_addr   <= '0;
      buf_wdata  <= '0;
      done_valid <= 1'b0;
      frame_len  <= '0;
      frame_err  <= 1'b0;
      err_code   <= '0;
      drop_cnt   <= '0;
`ifdef MSG_FRAME_CSUM_EN
      csumQ      <= '0;
`endif
    end else begin
      state      <= stateNext;
      lenQ       <= lenNext;
      idxQ       <= idxNext;
      buf_we     <= weNext;
      buf_addr   <= addrNext;
      buf_wdata  <= wdataNext;
      done_valid <= doneNext;
      frame_len  <= flenNext;
      frame_err  <= errNext;
      err_code   <= codeNext;
      drop_cnt   <= dropNext;
`ifdef MSG_FRAME_CSUM_EN
      csumQ      <= csumNext;
`endif
    end
  end

  always_comb begin
    stateNext = state;
    lenNext   = lenQ;
    idxNext   = idxQ;
    weNext    = 1'b0;
    addrNext  = buf_addr;
    wdataNext = buf_wdata;
    doneNext  = done_valid;
    flenNext  = frame_len;
    errNext   = 1'b0;
    codeNext  = err_code;
    dropNext  = drop_cnt;
`ifdef MSG_FRAME_CSUM_EN
    csumNext  = csumQ;
`endif
    case (state)
      IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) stateNext = LEN;
      end
      LEN: begin
        if (timeout) begin
          errNext = 1'b1; codeNext = ERR_TIMEOUT; stateNext = IDLE;
        end else if (rx_valid) begin
          if ((rx_data != 8'd0) && (rx_data <= MAX_LEN_B)) begin
            lenNext   = rx_data[3:0];
            idxNext   = '0;
            stateNext = DATA;
`ifdef MSG_FRAME_CSUM_EN
            csumNext  = rx_data;
`endif
          end else begin
            errNext = 1'b1; codeNext = ERR_BADLEN; stateNext = IDLE;
          end
        end
      end
      DATA: begin
        if (timeout) begin
          errNext = 1'b1; codeNext = ERR_TIMEOUT; stateNext = IDLE;
        end else if (rx_valid) begin
          weNext    = 1'b1;
          addrNext  = idxQ;
          wdataNext = rx_data;
          idxNext   = idxQ + 4'd1;
`ifdef MSG_FRAME_CSUM_EN
          csumNext  = csumQ ^ rx_data;
`endif
          if (idxQ == lenQ - 4'd1) begin
`ifdef MSG_FRAME_CSUM_EN
            stateNext = CSUM;
`else
            stateNext = HOLD; doneNext = 1'b1; flenNext = lenQ;
`endif
          end
        end
      end
`ifdef MSG_FRAME_CSUM_EN
      CSUM: begin
        if (timeout) begin
          errNext = 1'b1; codeNext = ERR_TIMEOUT; stateNext = IDLE;
        end else if (rx_valid) begin
          if (rx_data == csumQ) begin
            stateNext = HOLD; doneNext = 1'b1; flenNext = lenQ;
          end else begin
            errNext = 1'b1; codeNext = ERR_CSUM; stateNext = IDLE;
          end
        end
      end
`endif
      HOLD: begin
        // Bytes arriving while the consumer owns the buffer are only counted.
        if (rx_valid) dropNext = satInc8(drop_cnt);
        if (done_ack) begin
          doneNext  = 1'b0;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_msg_frame_ctrl.sv
// Self-checking bench for msg_frame_ctrl: frame-level reference model plus directed scenarios.
module tb_msg_frame_ctrl;

  localparam int         MAX_LEN     = 10;
  localparam int         TIMEOUT_CYC = 69440;
  localparam logic [7:0] SYNC        = 8'h7E;
`ifdef MSG_FRAME_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       done_ack = 1'b0;
  logic       buf_we, done_valid, frame_err, busy;
  logic [3:0] buf_addr, frame_len;
  logic [7:0] buf_wdata, drop_cnt;
  logic [1:0] err_code;

  msg_frame_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .SYNC_BYTE(SYNC)) dut (
    .CLK(CLK), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .done_valid(done_valid), .done_ack(done_ack), .frame_len(frame_len),
    .frame_err(frame_err), .err_code(err_code), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 CLK = ~CLK;

  int nChecks = 0;
  int nErrors = 0;
  bit checkEn = 1'b0;

  // Reference model: tracks the frame as "collected bytes" rather than a state machine.
  bit         mInFrame = 0, mGotLen = 0, mHold = 0;
  int         mLen = 0, mIdle = 0;
  logic [7:0] mPay[$];
  logic       eWe = 0, eDone = 0, eErr = 0;
  logic [3:0] eAddr = 0, eFlen = 0;
  logic [7:0] eData = 0, eDrop = 0;
  logic [1:0] eCode = 0;

  function automatic logic [7:0] frameSum();
    logic [7:0] s = 8'(mLen);
    foreach (mPay[i]) s ^= mPay[i];
    return s;
  endfunction

  task automatic mFail(input logic [1:0] c);
    mInFrame = 0; eErr = 1; eCode = c;
  endtask

  task automatic mDone();
    mInFrame = 0; mHold = 1; eDone = 1; eFlen = 4'(mLen);
  endtask

  always @(posedge CLK or negedge reset) begin
    if (!reset) begin
      mInFrame = 0; mGotLen = 0; mHold = 0; mLen = 0; mIdle = 0; mPay.delete();
      eWe = 0; eDone = 0; eErr = 0; eAddr = 0; eFlen = 0; eData = 0; eDrop = 0; eCode = 0;
    end else begin
      eWe = 0; eErr = 0;
      if (mHold) begin
        if (rx_valid) eDrop = (eDrop == 8'd255) ? eDrop : eDrop + 8'd1;
        if (done_ack) begin mHold = 0; eDone = 0; end
      end else if (!mInFrame) begin
        if (rx_valid && rx_data == SYNC) begin
          mInFrame = 1; mGotLen = 0; mPay.delete(); mIdle = 0;
        end
      end else if (rx_valid) begin
        mIdle = 0;
        if (!mGotLen) begin
          if (rx_data >= 1 && rx_data <= MAX_LEN) begin mLen = rx_data; mGotLen = 1; end
          else mFail(2'd1);
        end else if (mPay.size() < mLen) begin
          eWe = 1; eAddr = 4'(mPay.size()); eData = rx_data;
          mPay.push_back(rx_data);
          if (mPay.size() == mLen && !CSUM_EN) mDone();
        end else begin
          if (rx_data == frameSum()) mDone();
          else mFail(2'd3);
        end
      end else begin
        mIdle++;
        if (mIdle == TIMEOUT_CYC) mFail(2'd2);
      end
    end
  end

  always @(negedge CLK) begin
    if (checkEn) begin
      nChecks++;
      if ({buf_we, buf_addr, buf_wdata, done_valid, frame_len, frame_err, err_code, busy, drop_cnt} !==
          {eWe, eAddr, eData, eDone, eFlen, eErr, eCode, (mInFrame | mHold), eDrop}) begin
        nErrors++;
        $display("FAIL cycle@%0t: we/addr/data=%b/%h/%h exp %b/%h/%h done/len=%b/%h exp %b/%h err/code=%b/%h exp %b/%h busy=%b exp %b drop=%h exp %h",
                 $time, buf_we, buf_addr, buf_wdata, eWe, eAddr, eData, done_valid, frame_len, eDone, eFlen,
                 frame_err, err_code, eErr, eCode, busy, (mInFrame | mHold), drop_cnt, eDrop);
      end
    end
  end

  // Observation log used by the hand-computed expectations.
  logic [11:0] wrLog[$];
  int          errPulses = 0;
  logic [1:0]  lastCode = 0;
  int          doneCycles = 0;

  always @(negedge CLK) begin
    if (buf_we) wrLog.push_back({buf_addr, buf_wdata});
    if (frame_err) begin errPulses++; lastCode = err_code; end
    if (done_valid) doneCycles++;
  end

  function automatic int wrAt(input int i);
    return (i < wrLog.size()) ? int'(wrLog[i]) : -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic sendB(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    @(posedge CLK); #1;
    rx_valid = 1'b0;
  endtask

  task automatic ack();
    done_ack = 1'b1;
    @(posedge CLK); #1;
    done_ack = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    chk({tag, "_we"},    int'(buf_we), 0);
    chk({tag, "_addr"},  int'(buf_addr), 0);
    chk({tag, "_wdata"}, int'(buf_wdata), 0);
    chk({tag, "_done"},  int'(done_valid), 0);
    chk({tag, "_flen"},  int'(frame_len), 0);
    chk({tag, "_err"},   int'(frame_err), 0);
    chk({tag, "_code"},  int'(err_code), 0);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_drop"},  int'(drop_cnt), 0);
  endtask

  task automatic doReset();
    @(posedge CLK); #1;
    reset = 1'b0;
    #2;
    checkResetState("rst");
    @(posedge CLK); #1;
    reset = 1'b1;
    idle(1);
  endtask

  int wb, eb, db;

  initial begin
    #3 reset = 1'b0;
    checkEn = 1'b1;
    #20 reset = 1'b1;
    idle(1);
    checkResetState("por");

    // Noise in IDLE and a stray ack are ignored.
    sendB(8'h55); ack(); idle(2);
    chk("idle_busy", int'(busy), 0);

    // Basic three-byte frame.
    wb = wrLog.size(); eb = errPulses;
    sendB(SYNC); sendB(8'h03); sendB(8'h11); sendB(8'h22); sendB(8'h33); sendB(8'h03);
    idle(3);
    chk("f1_nwr", wrLog.size() - wb, 3);
    chk("f1_w0", wrAt(wb), 12'h011);
    chk("f1_w1", wrAt(wb + 1), 12'h122);
    chk("f1_w2", wrAt(wb + 2), 12'h233);
    chk("f1_done", int'(done_valid), 1);
    chk("f1_len", int'(frame_len), 3);
    chk("f1_noerr", errPulses - eb, 0);
    chk("f1_drop", int'(drop_cnt), CSUM_EN ? 0 : 1);
    ack(); idle(2);
    chk("f1_ackdone", int'(done_valid), 0);
    chk("f1_ackbusy", int'(busy), 0);

    // Bad lengths: zero and MAX_LEN+1.
    wb = wrLog.size(); eb = errPulses;
    sendB(SYNC); sendB(8'h00); idle(3);
    chk("len0_err", errPulses - eb, 1);
    chk("len0_code", int'(lastCode), 1);
    chk("len0_nwr", wrLog.size() - wb, 0);
    chk("len0_busy", int'(busy), 0);
    sendB(SYNC); sendB(8'h0B); idle(3);
    chk("len11_err", errPulses - eb, 2);
    chk("len11_code", int'(err_code), 1);

    // Maximum length frame, payload 01..0A, checksum 01.
    wb = wrLog.size();
    sendB(SYNC); sendB(8'h0A);
    for (int i = 1; i <= 10; i++) sendB(8'(i));
    sendB(8'h01); idle(3);
    chk("max_nwr", wrLog.size() - wb, 10);
    chk("max_w9", wrAt(wb + 9), 12'h90A);
    chk("max_len", int'(frame_len), 10);
    chk("max_done", int'(done_valid), 1);
    ack(); idle(2);

    // SYNC inside payload, then checksum mismatch (expected 7D).
    doReset();
    wb = wrLog.size(); eb = errPulses; db = doneCycles;
    sendB(SYNC); sendB(8'h02); sendB(8'h7E); sendB(8'h01); sendB(8'hFF); idle(3);
    chk("cs_nwr", wrLog.size() - wb, 2);
    chk("cs_w0", wrAt(wb), 12'h07E);
    chk("cs_w1", wrAt(wb + 1), 12'h101);
`ifdef MSG_FRAME_CSUM_EN
    chk("cs_err", errPulses - eb, 1);
    chk("cs_code", int'(lastCode), 3);
    chk("cs_nodone", doneCycles - db, 0);
`else
    chk("cs_err", errPulses - eb, 0);
    chk("cs_done", int'(done_valid), 1);
    chk("cs_len", int'(frame_len), 2);
    chk("cs_drop", int'(drop_cnt), 1);
`endif

    // Drops in HOLD, ack with simultaneous byte, then a new frame.
    doReset();
    sendB(SYNC); sendB(8'h02); sendB(8'h10); sendB(8'h20); sendB(8'h32);
    sendB(8'hAA); sendB(8'hBB); sendB(8'hCC); idle(2);
    chk("hold_drop3", int'(drop_cnt), CSUM_EN ? 3 : 4);
    chk("hold_done", int'(done_valid), 1);
    rx_valid = 1'b1; rx_data = 8'hDD; done_ack = 1'b1;
    @(posedge CLK); #1;
    rx_valid = 1'b0; done_ack = 1'b0;
    idle(1);
    chk("ackrx_drop", int'(drop_cnt), CSUM_EN ? 4 : 5);
    chk("ackrx_done", int'(done_valid), 0);
    wb = wrLog.size();
    sendB(SYNC); sendB(8'h01); sendB(8'h55); sendB(8'h54); idle(3);
    chk("f2_done", int'(done_valid), 1);
    chk("f2_len", int'(frame_len), 1);
    chk("f2_w0", wrAt(wb), 12'h055);
    for (int i = 0; i < 260; i++) sendB(8'(i));
    idle(1);
    chk("drop_sat", int'(drop_cnt), 255);
    ack(); idle(2);

    // Inter-byte timeout.
    doReset();
    wb = wrLog.size(); eb = errPulses; db = doneCycles;
    sendB(SYNC); sendB(8'h02); sendB(8'hAA);
    idle(TIMEOUT_CYC - 3);
    chk("to_early", errPulses - eb, 0);
    chk("to_busy_early", int'(busy), 1);
    idle(8);
    chk("to_err", errPulses - eb, 1);
    chk("to_code", int'(lastCode), 2);
    chk("to_w0", wrAt(wb), 12'h0AA);
    chk("to_nwr", wrLog.size() - wb, 1);
    chk("to_nodone", doneCycles - db, 0);
    chk("to_busy", int'(busy), 0);

    // Reset in the middle of a frame, right as a write strobe is out.
    doReset();
    sendB(SYNC); sendB(8'h05); sendB(8'h11);
    chk("mid_we", int'(buf_we), 1);
    reset = 1'b0;
    #2;
    checkResetState("mid");
    @(posedge CLK); #1;
    reset = 1'b1;
    idle(1);
    sendB(SYNC); sendB(8'h01); sendB(8'h55); sendB(8'h54); idle(3);
    chk("post_done", int'(done_valid), 1);
    chk("post_len", int'(frame_len), 1);
    ack(); idle(3);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
